// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, exception codes and FSM state encoding for the LSU.
// No ports; imported by lsu_lane_align and lsu_mem_master.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_SIZE     = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: req/ack data-memory bus between the LSU (master) and DMEM (slave).
// Signals: MEM_req, MEM_we, MEM_addr[ADDR_W], MEM_be[4], MEM_wdata[32] toward memory;
//          MEM_rdata[32], MEM_ack back from memory.
interface lsu_mem_master_if #(parameter int ADDR_W = 8);
    logic              MEM_req;
    logic              MEM_we;
    logic [ADDR_W-1:0] MEM_addr;
    logic [3:0]        MEM_be;
    logic [31:0]       MEM_wdata;
    logic [31:0]       MEM_rdata;
    logic              MEM_ack;

    modport master (output MEM_req, MEM_we, MEM_addr, MEM_be, MEM_wdata,
                    input  MEM_rdata, MEM_ack);
    modport slave  (input  MEM_req, MEM_we, MEM_addr, MEM_be, MEM_wdata,
                    output MEM_rdata, MEM_ack);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane logic -- misalign flag, byte enables,
// lane-replicated store data and extracted/extended load data.
// Ports: size_i, lo_i (addr[1:0]), unsigned_i, wdata_i, rdata_i ->
//        misalign_o, be_o, wdata_o, rdata_o.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        misalign_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = rdata_i[{lo_i, 3'b000} +: 8];
        h          = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        misalign_o = (size_i == SZ_HALF && lo_i[0]) || (size_i == SZ_WORD && lo_i != 2'b00);
        be_o       = size_i == SZ_BYTE ? 4'b0001 << lo_i :
                     size_i == SZ_HALF ? (lo_i[1] ? 4'b1100 : 4'b0011) :
                     size_i == SZ_WORD ? 4'b1111 : 4'b0000;
        wdata_o    = size_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                     size_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o    = size_i == SZ_BYTE ? {{24{~unsigned_i & b[7]}}, b} :
                     size_i == SZ_HALF ? {{16{~unsigned_i & h[15]}}, h} : rdata_i;
    end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store unit driving a req/ack handshake to data memory.
// Ports: SYS_clk, SYS_reset (async active-low); LSU_req/we/size/unsigned/addr/wdata in;
//        LSU_busy/done/rdata/exc_code/badvaddr out; mem (lsu_mem_master_if.master).
// Optional: define LSU_TIMEOUT_EN to abort a REQ after TIMEOUT_CYC cycles without ack.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        LSU_req,
    input  logic        LSU_we,
    input  logic [1:0]  LSU_size,
    input  logic        LSU_unsigned,
    input  logic [31:0] LSU_addr,
    input  logic [31:0] LSU_wdata,
    output logic        LSU_busy,
    output logic        LSU_done,
    output logic [31:0] LSU_rdata,
    output logic [1:0]  LSU_exc_code,
    output logic [31:0] LSU_badvaddr,
    lsu_mem_master_if.master mem
);
    logic [1:0]  state_q, state_d;
    logic        we_q, we_d, uns_q, uns_d;
    logic [1:0]  size_q, size_d, exc_q, exc_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, badv_q, badv_d;
    logic [3:0]  be_q, be_d;
    logic        idle, misalign, tmo;
    logic [1:0]  err;
    logic [3:0]  be_a;
    logic [31:0] wdata_a, rdata_a;

    assign idle = state_q == ST_IDLE;

    // In IDLE the aligner checks the incoming request; afterwards it sees the latched
    // access so the load lane extraction uses the captured size/offset.
    lsu_lane_align u_align (
        .size_i     (idle ? LSU_size : size_q),
        .lo_i       (idle ? LSU_addr[1:0] : addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (LSU_wdata),
        .rdata_i    (mem.MEM_rdata),
        .misalign_o (misalign),
        .be_o       (be_a),
        .wdata_o    (wdata_a),
        .rdata_o    (rdata_a)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Counter is held at zero outside REQ, so it starts from zero on REQ entry.
    assign cnt_d = state_q == ST_REQ ? cnt_q + 1'b1 : '0;
    assign tmo   = cnt_q == CW'(TIMEOUT_CYC - 1);
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
`else
    assign tmo = TIMEOUT_CYC < 0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        badv_d  = badv_q;
        err     = LSU_size == SZ_ILL ? EXC_SIZE : misalign ? EXC_MISALIGN : EXC_NONE;
        if (idle && LSU_req) begin
            we_d    = LSU_we;
            uns_d   = LSU_unsigned;
            size_d  = LSU_size;
            addr_d  = LSU_addr;
            wdata_d = wdata_a;
            be_d    = be_a;
            state_d = err != EXC_NONE ? ST_RESP : ST_REQ;
            if (err != EXC_NONE) begin
                exc_d  = err;
                badv_d = LSU_addr;
            end
        end else if (state_q == ST_REQ && mem.MEM_ack) begin
            rdata_d = we_q ? rdata_q : rdata_a;
            exc_d   = EXC_NONE;
            state_d = ST_RESP;
        end else if (state_q == ST_REQ && tmo) begin
            exc_d   = EXC_TIMEOUT;
            badv_d  = addr_q;
            state_d = ST_RESP;
        end else if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
            badv_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            badv_q  <= badv_d;
        end
    end

    assign LSU_busy      = !idle;
    assign LSU_done      = state_q == ST_RESP;
    assign LSU_rdata     = rdata_q;
    assign LSU_exc_code  = exc_q;
    assign LSU_badvaddr  = badv_q;
    assign mem.MEM_req   = state_q == ST_REQ;
    assign mem.MEM_we    = mem.MEM_req & we_q;
    assign mem.MEM_addr  = addr_q[ADDR_W+1:2];
    assign mem.MEM_be    = mem.MEM_req ? be_q : 4'b0000;
    assign mem.MEM_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed and randomized checks of lsu_mem_master against a behavioural model.
module tb_lsu_mem_master;
    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] rdata, badv;
    logic [1:0]  exc;
    int          total = 0, bad = 0;
    logic [31:0] m_rdata = '0;
    int          r_lat, r_nreq, r_ndone;
    logic        r_stable, r_beleak, r_we;
    logic [7:0]  r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata, r_rdata, r_badv;
    logic [1:0]  r_exc;

    lsu_mem_master_if #(.ADDR_W(8)) mem ();

    lsu_mem_master #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
        .SYS_clk(clk), .SYS_reset(rst_n), .LSU_req(req), .LSU_we(we), .LSU_size(sz),
        .LSU_unsigned(uns), .LSU_addr(addr), .LSU_wdata(wdata), .LSU_busy(busy),
        .LSU_done(done), .LSU_rdata(rdata), .LSU_exc_code(exc), .LSU_badvaddr(badv),
        .mem(mem)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_err(input logic [1:0] s, input logic [31:0] a);
        int off = int'(a % 4);
        if (s == 2'd3) return 2'd3;
        if ((s == 2'd1 && off % 2 != 0) || (s == 2'd2 && off != 0)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
        int off = int'(a % 4);
        if (s == 2'd0) return 4'(1 << off);
        if (s == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] s, input logic [31:0] d);
        logic [63:0] v = {32'b0, d};
        if (s == 2'd0) return 32'((v % 256) * 32'h0101_0101);
        if (s == 2'd1) return 32'((v % 65536) * 32'h0001_0001);
        return d;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
        int   off  = int'(a % 4);
        int   n    = s == 2'd0 ? 8 : s == 2'd1 ? 16 : 32;
        logic [63:0] mask = (64'd1 << n) - 64'd1;
        logic [63:0] v = ({32'b0, d} >> (8 * off)) & mask;
        if (!u && v[n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_access(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int waits, input logic poke);
        @(negedge clk);
        req = 1'b1; we = w; sz = s; uns = u; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0; addr = $urandom; wdata = $urandom; sz = 2'($urandom); uns = ~u; we = ~w;
        r_lat = 0; r_nreq = 0; r_ndone = 0; r_stable = 1'b1; r_beleak = 1'b0;
        for (int k = 1; k <= 40 && !(r_ndone > 0 && k > r_lat + 1); k++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem.MEM_req) begin
                r_nreq++;
                if (r_nreq == 1) begin
                    r_we = mem.MEM_we; r_addr = mem.MEM_addr; r_be = mem.MEM_be; r_wdata = mem.MEM_wdata;
                    if (poke) begin req = 1'b1; addr = $urandom; end
                end else if ({r_we, r_addr, r_be, r_wdata} !== {mem.MEM_we, mem.MEM_addr, mem.MEM_be, mem.MEM_wdata})
                    r_stable = 1'b0;
                mem.MEM_ack   = r_nreq == waits + 1;
                mem.MEM_rdata = r_nreq == waits + 1 ? rd : $urandom;
            end else begin
                if (mem.MEM_be !== 4'b0000) r_beleak = 1'b1;
                mem.MEM_ack   = 1'($urandom);
                mem.MEM_rdata = $urandom;
            end
            if (done) begin
                r_ndone++;
                if (r_ndone == 1) begin r_lat = k; r_rdata = rdata; r_exc = exc; r_badv = badv; end
            end
        end
        mem.MEM_ack = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if ({busy, done, mem.MEM_req, mem.MEM_we, mem.MEM_be, mem.MEM_addr, mem.MEM_wdata, rdata, exc, badv} !== '0) begin
            bad++; $display("FAIL reset_outputs got busy=%b done=%b req=%b be=%h rdata=%h exc=%h badv=%h exp all zero",
                            busy, done, mem.MEM_req, mem.MEM_be, rdata, exc, badv); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_word_store;
        run_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h5555_AAAA, 0, 1'b0);
        total++; if (r_addr !== 8'h04) begin bad++; $display("FAIL ws_addr got=%h exp=04", r_addr); end
        total++; if (r_be !== 4'b1111) begin bad++; $display("FAIL ws_be got=%b exp=1111", r_be); end
        total++; if (r_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ws_wdata got=%h exp=deadbeef", r_wdata); end
        total++; if (r_we !== 1'b1) begin bad++; $display("FAIL ws_we got=%b exp=1", r_we); end
        total++; if (r_lat !== 2) begin bad++; $display("FAIL ws_latency got=%0d exp=2", r_lat); end
        total++; if (r_exc !== 2'b00) begin bad++; $display("FAIL ws_exc got=%b exp=00", r_exc); end
        total++; if (r_rdata !== m_rdata) begin bad++; $display("FAIL ws_rdata_hold got=%h exp=%h", r_rdata, m_rdata); end
    endtask

    task automatic test_byte_load;
        run_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FF_0102, 1, 1'b0);
        total++; if (r_be !== 4'b1000) begin bad++; $display("FAIL bl_be got=%b exp=1000", r_be); end
        total++; if (r_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL bl_signed got=%h exp=ffffff80", r_rdata); end
        total++; if (r_lat !== 3) begin bad++; $display("FAIL bl_latency got=%0d exp=3", r_lat); end
        run_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF_0102, 0, 1'b0);
        total++; if (r_rdata !== 32'h0000_0080) begin bad++; $display("FAIL bl_unsigned got=%h exp=00000080", r_rdata); end
        m_rdata = 32'h0000_0080;
    endtask

    task automatic test_half;
        run_access(1'b1, 2'd1, 1'b0, 32'h06, 32'h1234_ABCD, 32'h0, 0, 1'b0);
        total++; if (r_be !== 4'b1100) begin bad++; $display("FAIL hs_be got=%b exp=1100", r_be); end
        total++; if (r_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL hs_wdata got=%h exp=abcdabcd", r_wdata); end
        run_access(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, 32'h1111_2222, 0, 1'b0);
        total++; if (r_nreq !== 0) begin bad++; $display("FAIL hm_memreq got=%0d exp=0", r_nreq); end
        total++; if (r_lat !== 1) begin bad++; $display("FAIL hm_latency got=%0d exp=1", r_lat); end
        total++; if (r_exc !== 2'b01) begin bad++; $display("FAIL hm_exc got=%b exp=01", r_exc); end
        total++; if (r_badv !== 32'h05) begin bad++; $display("FAIL hm_badv got=%h exp=00000005", r_badv); end
        total++; if (r_rdata !== m_rdata) begin bad++; $display("FAIL hm_rdata_hold got=%h exp=%h", r_rdata, m_rdata); end
    endtask

    task automatic test_wait_poke;
        run_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 3, 1'b1);
        total++; if (r_nreq !== 4) begin bad++; $display("FAIL wp_req_cycles got=%0d exp=4", r_nreq); end
        total++; if (r_stable !== 1'b1) begin bad++; $display("FAIL wp_stable got=%b exp=1", r_stable); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL wp_done_count got=%0d exp=1", r_ndone); end
        total++; if (r_lat !== 5) begin bad++; $display("FAIL wp_latency got=%0d exp=5", r_lat); end
        total++; if (r_addr !== 8'h10) begin bad++; $display("FAIL wp_addr got=%h exp=10", r_addr); end
        total++; if (r_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL wp_rdata got=%h exp=cafef00d", r_rdata); end
        m_rdata = 32'hCAFE_F00D;
    endtask

    task automatic test_reset_mid;
        int nd = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; sz = 2'd2; addr = 32'h20; mem.MEM_ack = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        total++; if (mem.MEM_req !== 1'b1) begin bad++; $display("FAIL rm_in_req got=%b exp=1", mem.MEM_req); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem.MEM_req !== 1'b0) begin bad++; $display("FAIL rm_req_drop got=%b exp=0", mem.MEM_req); end
        total++; if ({busy, done, rdata} !== '0) begin bad++; $display("FAIL rm_state got busy=%b done=%b rdata=%h exp 0", busy, done, rdata); end
        m_rdata = '0;
        repeat (3) begin @(negedge clk); if (done) nd++; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); if (done) nd++; end
        total++; if (nd !== 0) begin bad++; $display("FAIL rm_no_done got=%0d exp=0", nd); end
        run_access(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, 32'h0BAD_C0DE, 0, 1'b0);
        total++; if ({r_rdata, r_exc, 6'(r_lat)} !== {32'h0BAD_C0DE, 2'b00, 6'd2}) begin
            bad++; $display("FAIL rm_after got rdata=%h exc=%b lat=%0d exp 0badc0de/00/2", r_rdata, r_exc, r_lat); end
        m_rdata = 32'h0BAD_C0DE;
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            logic        w  = 1'($urandom);
            logic [1:0]  s  = 2'($urandom);
            logic        u  = 1'($urandom);
            logic [31:0] a  = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rd = $urandom;
            int          wt = int'($urandom_range(0, 3));
            logic [1:0]  e  = m_err(s, a);
            run_access(w, s, u, a, wd, rd, wt, 1'($urandom));
            total++; if (r_ndone !== 1 || r_beleak !== 1'b0) begin bad++; $display("FAIL rnd%0d_done got=%0d leak=%b exp=1/0", i, r_ndone, r_beleak); end
            if (e != 2'd0) begin
                total++; if ({r_exc, r_badv, 6'(r_nreq), 6'(r_lat), r_rdata} !== {e, a, 6'd0, 6'd1, m_rdata}) begin
                    bad++; $display("FAIL rnd%0d_err got exc=%b badv=%h nreq=%0d lat=%0d rdata=%h exp %b/%h/0/1/%h",
                                    i, r_exc, r_badv, r_nreq, r_lat, r_rdata, e, a, m_rdata); end
            end else begin
                if (!w) m_rdata = m_rd(s, u, a, rd);
                total++; if ({r_exc, 6'(r_nreq), 6'(r_lat), r_stable, r_we, r_addr, r_be} !== {2'b00, 6'(wt + 1), 6'(wt + 2), 1'b1, w, a[9:2], m_be(s, a)}) begin
                    bad++; $display("FAIL rnd%0d_bus got exc=%b nreq=%0d lat=%0d stable=%b we=%b addr=%h be=%b exp 00/%0d/%0d/1/%b/%h/%b",
                                    i, r_exc, r_nreq, r_lat, r_stable, r_we, r_addr, r_be, wt + 1, wt + 2, w, a[9:2], m_be(s, a)); end
                total++; if (r_rdata !== m_rdata) begin bad++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, r_rdata, m_rdata); end
                if (w) begin
                    total++; if (r_wdata !== m_wd(s, wd)) begin bad++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, r_wdata, m_wd(s, wd)); end
                end
            end
        end
    endtask

    task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
        run_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h1357_9BDF, -1, 1'b0);
        total++; if (r_nreq !== 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", r_nreq); end
        total++; if ({r_exc, r_badv, 6'(r_lat), r_rdata} !== {2'b10, 32'h30, 6'd17, m_rdata}) begin
            bad++; $display("FAIL to_result got exc=%b badv=%h lat=%0d rdata=%h exp 10/30/17/%h", r_exc, r_badv, r_lat, r_rdata, m_rdata); end
        run_access(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, 32'h2468_ACE0, 15, 1'b0);
        total++; if ({r_exc, 6'(r_nreq), 6'(r_lat), r_rdata} !== {2'b00, 6'd16, 6'd17, 32'h2468_ACE0}) begin
            bad++; $display("FAIL to_ack_wins got exc=%b nreq=%0d lat=%0d rdata=%h exp 00/16/17/2468ace0", r_exc, r_nreq, r_lat, r_rdata); end
        m_rdata = 32'h2468_ACE0;
`else
        run_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h1357_9BDF, 20, 1'b0);
        total++; if ({r_exc, 6'(r_nreq), 6'(r_lat), r_rdata} !== {2'b00, 6'd21, 6'd22, 32'h1357_9BDF}) begin
            bad++; $display("FAIL no_timeout got exc=%b nreq=%0d lat=%0d rdata=%h exp 00/21/22/13579bdf", r_exc, r_nreq, r_lat, r_rdata); end
        m_rdata = 32'h1357_9BDF;
`endif
    endtask

    initial begin
        mem.MEM_ack   = 1'b0;
        mem.MEM_rdata = '0;
        test_reset;
        test_word_store;
        test_byte_load;
        test_half;
        test_wait_poke;
        test_reset_mid;
        test_random;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit that acts as the initiator toward the data memory.
- Takes one byte, halfword or word access per request from the CPU datapath.
- Checks alignment, builds the word address, byte enables and lane-replicated write data, then drives a req/ack handshake to the memory.
- Returns sign- or zero-extended load data plus an exception code. Sits between the ALU address output and DMEM.

Parameters:
- ADDR_W, 8, word-address width toward memory (8 gives 256 words).
- TIMEOUT_CYC, 16, REQ-state cycles without ack before a bus-timeout error; used only with LSU_TIMEOUT_EN.

Ports:
- SYS_clk  in  1  single clock; all logic on rising edge.
- SYS_reset  in  1  asynchronous, active-low reset.
- LSU_req  in  1  access request; sampled only in IDLE.
- LSU_we  in  1  1 = store, 0 = load.
- LSU_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- LSU_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- LSU_addr  in  32  byte address.
- LSU_wdata  in  32  store data, right-justified.
- LSU_busy  out  1  high in every state except IDLE.
- LSU_done  out  1  one-cycle completion pulse.
- LSU_rdata  out  32  extended load data.
- LSU_exc_code  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal size; valid with LSU_done.
- LSU_badvaddr  out  32  faulting byte address; valid when LSU_exc_code != 00.
- MEM_req  out  1  memory request; held until ack.
- MEM_we  out  1  write enable.
- MEM_addr  out  ADDR_W  word address = LSU_addr[ADDR_W+1:2]; upper bits ignored.
- MEM_be  out  4  byte enables, lane n = bits 8n+7:8n (little-endian).
- MEM_wdata  out  32  lane-replicated store data.
- MEM_rdata  in  32  read data; valid in the cycle MEM_ack is high.
- MEM_ack  in  1  completion; meaningful only while MEM_req is high.

Behaviour:
- Reset (async assert, synchronous release): state IDLE.
  - All outputs 0: LSU_rdata, LSU_badvaddr, LSU_exc_code, LSU_done, LSU_busy, MEM_*.
  - Reset mid-access drops MEM_req immediately, with no completion pulse.
- States: IDLE, REQ, RESP.
- IDLE:
  - LSU_req=1 at a clock edge latches we, size, unsigned, addr and wdata.
  - Illegal size, or a misaligned address, goes to RESP with the error code and LSU_badvaddr=addr. No memory access is made.
    - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise goes to REQ.
- REQ: MEM_req=1 with all MEM_* driven from registers and stable until ack.
  - MEM_ack=1 at an edge: for a load, capture, extract and extend MEM_rdata into LSU_rdata; then go to RESP.
- RESP: LSU_done=1 for exactly one cycle, then IDLE.
  - A new LSU_req can be accepted on the next cycle (IDLE), no sooner.
- Latency: zero-wait ack gives done 2 cycles after the accepting edge (accept → REQ → RESP). Each memory wait state adds 1. An error gives done 1 cycle after accept.
- Byte enables: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111. MEM_be is 0 when MEM_req=0.
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Read data: lane selected by addr[1:0] (byte) or addr[1] (half), extended per LSU_unsigned. Word reads pass through unchanged.
- LSU_rdata holds until the next successful load completes; stores and errors leave it unchanged.
- LSU_exc_code and LSU_badvaddr update at RESP entry and hold until the next RESP.
- LSU_req while busy is ignored; nothing is queued.
- MEM_ack outside REQ is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - Counter clears on REQ entry and increments each REQ cycle without ack.
  - Reaching TIMEOUT_CYC drops MEM_req, goes to RESP with LSU_exc_code=10, badvaddr=addr, rdata unchanged.
  - Ack on the same edge as the timeout wins (normal completion).
- Undefined: no counter, REQ waits indefinitely, code 10 never produced.

Decomposition:
- Shared package lsu_pkg: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), exception codes (EXC_NONE/EXC_MISALIGN/EXC_TIMEOUT/EXC_SIZE), state encoding.
- One combinational sub-module, lsu_lane_align: computes misalign flag, MEM_be, replicated wdata and extended rdata from size, addr[1:0] and unsigned.
- The FSM, registers and timeout counter stay in lsu_mem_master.

Test Plan:
- Word store addr=0x0000_0010, wdata=0xDEADBEEF, ack on first REQ cycle → MEM_addr=0x04, MEM_be=1111, MEM_wdata=0xDEADBEEF; LSU_done 2 cycles after accept; exc=00.
- Byte load addr=0x13, signed, MEM_rdata=0x80FF_0102 → MEM_be=1000, LSU_rdata=0xFFFF_FF80. Same with unsigned → 0x0000_0080.
- Half store addr=0x06, wdata=0x1234_ABCD → MEM_be=1100, MEM_wdata=0xABCD_ABCD. Half load addr=0x05 → no MEM_req; done 1 cycle after accept, exc=01, badvaddr=0x05.
- Load with ack delayed 3 cycles, LSU_req pulsed during REQ → MEM_req high for 4 cycles with stable MEM_*; the extra request is ignored; exactly one done.
- SYS_reset asserted while in REQ → MEM_req=0 immediately, no done; after release, a word load completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYC=16, no ack → MEM_req high for 16 cycles then low, done with exc=10. Ack on the 16th cycle → normal completion, exc=00.
